// File: rtl/box_field_ctrl_pkg.sv
// Shared definitions for the destructible-box field: direction bit indices,
// sprite size defaults, colour width, scan FSM states and a coordinate helper.
package box_field_ctrl_pkg;

   localparam int DIR_LEFT  = 0;
   localparam int DIR_RIGHT = 1;
   localparam int DIR_UP    = 2;
   localparam int DIR_DOWN  = 3;

   localparam int TILE_W_DEF = 16;
   localparam int TILE_H_DEF = 16;
   localparam int B_W_DEF    = 16;
   localparam int B_H_DEF    = 16;
   localparam int RGB_W      = 12;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } scan_state_t;

   // Widen a 10-bit screen coordinate so that x-R and x+R never wrap.
   function automatic logic signed [11:0] to_s12(input logic [9:0] a);
      return $signed({2'b00, a});
   endfunction

endpackage

// File: rtl/box_geom_cmp.sv
// Pure combinational geometry for one box: pixel cover, the four blocked
// terms against bomberman and plus-shaped blast overlap.
module box_geom_cmp
   import box_field_ctrl_pkg::*;
#(
   parameter int TILE_W      = TILE_W_DEF,
   parameter int TILE_H      = TILE_H_DEF,
   parameter int B_W         = B_W_DEF,
   parameter int B_H         = B_H_DEF,
   parameter int BLAST_RANGE = 3
)(
   input  logic [9:0] box_x,
   input  logic [9:0] box_y,
   input  logic [9:0] v_x,
   input  logic [9:0] v_y,
   input  logic [9:0] b_x,
   input  logic [9:0] b_y,
   input  logic [9:0] e_x,
   input  logic [9:0] e_y,
   output logic       pix_hit,
   output logic [3:0] blk,
   output logic       blast_hit
);

   localparam logic signed [11:0] TW  = 12'(TILE_W);
   localparam logic signed [11:0] TH  = 12'(TILE_H);
   localparam logic signed [11:0] BW  = 12'(B_W);
   localparam logic signed [11:0] BH  = 12'(B_H);
   localparam logic signed [11:0] R   = 12'(BLAST_RANGE * TILE_W);
   localparam logic signed [11:0] ONE = 12'sd1;

   logic signed [11:0] x, y, vx, vy, bx, by, ex, ey;
   logic vov, hov, h_arm, v_arm;

   assign x  = to_s12(box_x);
   assign y  = to_s12(box_y);
   assign vx = to_s12(v_x);
   assign vy = to_s12(v_y);
   assign bx = to_s12(b_x);
   assign by = to_s12(b_y);
   assign ex = to_s12(e_x);
   assign ey = to_s12(e_y);

   assign pix_hit = (vx >= x) && (vx < x + TW) && (vy >= y) && (vy < y + TH);

   assign vov = (by < y + TH) && (by + BH > y);
   assign hov = (bx < x + TW) && (bx + BW > x);

   assign blk[DIR_LEFT]  = vov && (x < bx) && (bx <= x + TW);
   assign blk[DIR_RIGHT] = vov && (x - BW <= bx) && (bx < x);
   assign blk[DIR_UP]    = hov && (y < by) && (by <= y + TH);
   assign blk[DIR_DOWN]  = hov && (y - BH <= by) && (by < y);

   // Rectangle overlap of the box against each arm of the plus.
   assign h_arm = (x <= ex + R + TW - ONE) && (x + TW - ONE >= ex - R) &&
                  (y <= ey + TH - ONE)     && (y + TH - ONE >= ey);
   assign v_arm = (x <= ex + TW - ONE)     && (x + TW - ONE >= ex) &&
                  (y <= ey + R + TH - ONE) && (y + TH - ONE >= ey - R);

   assign blast_hit = h_arm || v_arm;

endmodule

// File: rtl/box_rom.sv
// Box sprite ROM: one registered read per cycle, shaded tile whose colour is
// {4'hC, row, col} so every texel of the sprite is distinct.
module box_rom
   import box_field_ctrl_pkg::*;
#(
   parameter int TILE_W = TILE_W_DEF,
   parameter int TILE_H = TILE_H_DEF
)(
   input  logic                        clk,
   input  logic [$clog2(TILE_H)-1:0]   row,
   input  logic [$clog2(TILE_W)-1:0]   col,
   output logic [RGB_W-1:0]            rgb
);

   always_ff @(posedge clk) begin
      rgb <= {4'hC, 4'(row), 4'(col)};
   end

endmodule

// File: rtl/box_field_ctrl.sv
// Destructible-box manager: alive state, one-box-per-cycle blast scan with a
// single pending slot, pixel overlay pipeline and bomberman blocked mask.
module box_field_ctrl
   import box_field_ctrl_pkg::*;
#(
   parameter int                      NUM_BOXES   = 2,
   parameter logic [NUM_BOXES*10-1:0] BOX_XS      = {10'd177, 10'd160},
   parameter logic [NUM_BOXES*10-1:0] BOX_YS      = {10'd67, 10'd50},
   parameter int                      TILE_W      = TILE_W_DEF,
   parameter int                      TILE_H      = TILE_H_DEF,
   parameter int                      B_W         = B_W_DEF,
   parameter int                      B_H         = B_H_DEF,
   parameter int                      BLAST_RANGE = 3
)(
   input  logic             clk,
   input  logic             reset_n,
   input  logic [9:0]       b_x,
   input  logic [9:0]       b_y,
   input  logic [9:0]       v_x,
   input  logic [9:0]       v_y,
   input  logic [9:0]       e_x,
   input  logic [9:0]       e_y,
   input  logic             explosion_SCEN,
   output logic             box_on,
   output logic [RGB_W-1:0] rgb_out,
   output logic [3:0]       bomberman_blocked,
   output logic [6:0]       boxes_left,
   output logic             box_destroyed,
   output logic             scan_busy,
   output logic             blast_overflow
);

   localparam int IW = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1;
   localparam int RW = $clog2(TILE_H);
   localparam int CW = $clog2(TILE_W);
   localparam logic [IW-1:0] LAST = IW'(NUM_BOXES - 1);

   scan_state_t          state, state_n;
   logic [IW-1:0]        idx, idx_n;
   logic [9:0]           scan_x, scan_y, scan_x_n, scan_y_n;
   logic                 pend_v, pend_v_n;
   logic [9:0]           pend_x, pend_y, pend_x_n, pend_y_n;
   logic                 ovf_n, dst_n;
   logic [NUM_BOXES-1:0] alive, alive_n;
   logic [6:0]           left_n;

   logic [NUM_BOXES-1:0] pix_hit_v, blast_v;
   logic [3:0]           blk_v [NUM_BOXES];

   logic                 hit_n, pix_hit_q;
   logic [RW-1:0]        row_n, pix_row_q;
   logic [CW-1:0]        col_n, pix_col_q;
   logic [3:0]           blk_n;

   for (genvar g = 0; g < NUM_BOXES; g++) begin : g_box
      box_geom_cmp #(
         .TILE_W(TILE_W), .TILE_H(TILE_H), .B_W(B_W), .B_H(B_H),
         .BLAST_RANGE(BLAST_RANGE)
      ) u_cmp (
         .box_x(BOX_XS[g*10 +: 10]), .box_y(BOX_YS[g*10 +: 10]),
         .v_x(v_x), .v_y(v_y), .b_x(b_x), .b_y(b_y),
         .e_x(scan_x), .e_y(scan_y),
         .pix_hit(pix_hit_v[g]), .blk(blk_v[g]), .blast_hit(blast_v[g])
      );
   end

   // Descending loop so the lowest-index live box wins the pixel.
   always_comb begin
      hit_n = 1'b0;
      row_n = '0;
      col_n = '0;
      blk_n = '0;
      for (int i = NUM_BOXES - 1; i >= 0; i--) begin
         if (alive[i] && pix_hit_v[i]) begin
            hit_n = 1'b1;
            row_n = RW'(v_y - BOX_YS[i*10 +: 10]);
            col_n = CW'(v_x - BOX_XS[i*10 +: 10]);
         end
         if (alive[i]) blk_n = blk_n | blk_v[i];
      end
   end

   always_comb begin
      state_n  = state;
      idx_n    = idx;
      scan_x_n = scan_x;
      scan_y_n = scan_y;
      pend_v_n = pend_v;
      pend_x_n = pend_x;
      pend_y_n = pend_y;
      ovf_n    = blast_overflow;
      alive_n  = alive;
      left_n   = boxes_left;
      dst_n    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pend_v) begin
               scan_x_n = pend_x;
               scan_y_n = pend_y;
               pend_v_n = 1'b0;
               idx_n    = '0;
               state_n  = ST_SCAN;
               if (explosion_SCEN) begin
                  pend_v_n = 1'b1;
                  pend_x_n = e_x;
                  pend_y_n = e_y;
               end
            end else if (explosion_SCEN) begin
               scan_x_n = e_x;
               scan_y_n = e_y;
               idx_n    = '0;
               state_n  = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (alive[idx] && blast_v[idx]) begin
               alive_n[idx] = 1'b0;
               left_n       = boxes_left - 7'd1;
               dst_n        = 1'b1;
            end
            if (idx == LAST) state_n = ST_IDLE;
            else             idx_n   = idx + 1'b1;
            if (explosion_SCEN) begin
               if (pend_v) begin
                  ovf_n = 1'b1;
               end else begin
                  pend_v_n = 1'b1;
                  pend_x_n = e_x;
                  pend_y_n = e_y;
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state             <= ST_IDLE;
         idx               <= '0;
         scan_x            <= '0;
         scan_y            <= '0;
         pend_v            <= 1'b0;
         pend_x            <= '0;
         pend_y            <= '0;
         blast_overflow    <= 1'b0;
         alive             <= '1;
         boxes_left        <= 7'(NUM_BOXES);
         box_destroyed     <= 1'b0;
         pix_hit_q         <= 1'b0;
         pix_row_q         <= '0;
         pix_col_q         <= '0;
         box_on            <= 1'b0;
         bomberman_blocked <= '0;
      end else begin
         state             <= state_n;
         idx               <= idx_n;
         scan_x            <= scan_x_n;
         scan_y            <= scan_y_n;
         pend_v            <= pend_v_n;
         pend_x            <= pend_x_n;
         pend_y            <= pend_y_n;
         blast_overflow    <= ovf_n;
         alive             <= alive_n;
         boxes_left        <= left_n;
         box_destroyed     <= dst_n;
         pix_hit_q         <= hit_n;
         pix_row_q         <= row_n;
         pix_col_q         <= col_n;
         box_on            <= pix_hit_q;
         bomberman_blocked <= blk_n;
      end
   end

   assign scan_busy = (state == ST_SCAN);

   box_rom #(.TILE_W(TILE_W), .TILE_H(TILE_H)) u_rom (
      .clk(clk), .row(pix_row_q), .col(pix_col_q), .rgb(rgb_out)
   );

endmodule
